// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback queue feeding the register-file write port
//
// Purpose: collects load and ALU results, queues them in acceptance order and
// drains them through the single register-file write port. It also reports
// pending writes and forwards the youngest pending value for two read addresses.
//
// Ports:
//   CLK, ResetN                      clock, asynchronous active-low reset
//   LoadValid/LoadReady/LoadRd/LoadData   load result handshake (priority)
//   AluValid/AluReady/AluRd/AluData       ALU result handshake
//   RegWrite/WriteAddress/WriteData       register-file write port (head entry)
//   WriteReady                       register file accepts the write this cycle
//   ReadReg1/ReadReg2                decode-stage source addresses
//   Busy1/Busy2, FwdData1/FwdData2   pending-write flag and youngest queued data
//   Count                            occupied entries
module regfile_writeback_queue #(
  parameter int REG_WIDTH          = 32,
  parameter int ADDRESS_PORT_WIDTH = 5,
  parameter int DEPTH              = 4
) (
  input  logic                            CLK,
  input  logic                            ResetN,
  input  logic                            LoadValid,
  output logic                            LoadReady,
  input  logic [ADDRESS_PORT_WIDTH-1:0]   LoadRd,
  input  logic [REG_WIDTH-1:0]            LoadData,
  input  logic                            AluValid,
  output logic                            AluReady,
  input  logic [ADDRESS_PORT_WIDTH-1:0]   AluRd,
  input  logic [REG_WIDTH-1:0]            AluData,
  output logic                            RegWrite,
  output logic [ADDRESS_PORT_WIDTH-1:0]   WriteAddress,
  output logic [REG_WIDTH-1:0]            WriteData,
  input  logic                            WriteReady,
  input  logic [ADDRESS_PORT_WIDTH-1:0]   ReadReg1,
  input  logic [ADDRESS_PORT_WIDTH-1:0]   ReadReg2,
  output logic                            Busy1,
  output logic                            Busy2,
  output logic [REG_WIDTH-1:0]            FwdData1,
  output logic [REG_WIDTH-1:0]            FwdData2,
  output logic [$clog2(DEPTH):0]          Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDRESS_PORT_WIDTH-1:0] rd_q   [DEPTH];
  logic [REG_WIDTH-1:0]          data_q [DEPTH];
  logic [PW-1:0]                 head_q, head_d;
  logic [PW-1:0]                 tail_q, tail_d;
  logic [CW-1:0]                 count_q, count_d;

  logic                          not_full;
  logic                          load_take;
  logic                          alu_take;
  logic                          push;
  logic                          pop;
  logic [ADDRESS_PORT_WIDTH-1:0] push_rd;
  logic [REG_WIDTH-1:0]          push_data;

  // Readiness looks at Count only, so a same-cycle pop never frees a slot.
  assign not_full  = (count_q < FULL);
  assign LoadReady = ResetN & not_full;
  assign AluReady  = ResetN & not_full & ~LoadValid;

  assign load_take = LoadValid & LoadReady;
  assign alu_take  = AluValid & AluReady;
  assign push_rd   = load_take ? LoadRd : AluRd;
  assign push_data = load_take ? LoadData : AluData;
  // Writes to x0 complete the handshake but are dropped.
  assign push      = (load_take | alu_take) & (push_rd != '0);

  assign RegWrite     = (count_q != '0);
  assign WriteAddress = RegWrite ? rd_q[head_q] : '0;
  assign WriteData    = RegWrite ? data_q[head_q] : '0;
  assign pop          = RegWrite & WriteReady;
  assign Count        = count_q;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_q[tail_q]   <= push_rd;
      data_q[tail_q] <= push_data;
    end
  end

  // Walk entries oldest to youngest so the last match wins (youngest value).
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    Busy1    = 1'b0;
    Busy2    = 1'b0;
    FwdData1 = '0;
    FwdData2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((ReadReg1 != '0) && (rd_q[idx] == ReadReg1)) begin
          Busy1    = 1'b1;
          FwdData1 = data_q[idx];
        end
        if ((ReadReg2 != '0) && (rd_q[idx] == ReadReg2)) begin
          Busy2    = 1'b1;
          FwdData2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed self-checking bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

  logic        CLK = 1'b0;
  logic        ResetN;
  logic        LoadValid, AluValid, WriteReady;
  logic        LoadReady, AluReady, RegWrite, Busy1, Busy2;
  logic [4:0]  LoadRd, AluRd, WriteAddress, ReadReg1, ReadReg2;
  logic [31:0] LoadData, AluData, WriteData, FwdData1, FwdData2;
  logic [2:0]  Count;

  int n_vec = 0;
  int n_err = 0;

  regfile_writeback_queue #(
    .REG_WIDTH(32), .ADDRESS_PORT_WIDTH(5), .DEPTH(4)
  ) dut (
    .CLK(CLK), .ResetN(ResetN),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadRd(LoadRd), .LoadData(LoadData),
    .AluValid(AluValid), .AluReady(AluReady), .AluRd(AluRd), .AluData(AluData),
    .RegWrite(RegWrite), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .WriteReady(WriteReady), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .Busy1(Busy1), .Busy2(Busy2), .FwdData1(FwdData1), .FwdData2(FwdData2),
    .Count(Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    ResetN = 1'b0; LoadValid = 1'b0; AluValid = 1'b0; WriteReady = 1'b0;
    LoadRd = '0; AluRd = '0; LoadData = '0; AluData = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // Reset state
    #12;
    check("rst_count", Count, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_loadready", LoadReady, 0);
    check("rst_aluready", AluReady, 0);
    check("rst_waddr", WriteAddress, 0);
    ResetN = 1'b1;
    tick();
    check("post_rst_loadready", LoadReady, 1);
    check("post_rst_aluready", AluReady, 1);

    // Single ALU result
    WriteReady = 1'b1; ReadReg1 = 5'd5;
    AluValid = 1'b1; AluRd = 5'd5; AluData = 32'hDEADBEEF;
    #1;
    check("single_busy_before", Busy1, 0);
    tick();
    AluValid = 1'b0; #1;
    check("single_regwrite", RegWrite, 1);
    check("single_waddr", WriteAddress, 5);
    check("single_wdata", WriteData, 32'hDEADBEEF);
    check("single_busy1", Busy1, 1);
    check("single_fwd1", FwdData1, 32'hDEADBEEF);
    tick();
    check("single_regwrite_done", RegWrite, 0);
    check("single_busy1_done", Busy1, 0);
    check("single_count_done", Count, 0);

    // Priority: load wins, ALU follows next cycle
    WriteReady = 1'b0; ReadReg1 = 5'd0;
    LoadValid = 1'b1; LoadRd = 5'd3; LoadData = 32'h33;
    AluValid = 1'b1; AluRd = 5'd4; AluData = 32'h44;
    #1;
    check("prio_loadready", LoadReady, 1);
    check("prio_aluready", AluReady, 0);
    tick();
    LoadValid = 1'b0; #1;
    check("prio_count1", Count, 1);
    check("prio_aluready_next", AluReady, 1);
    tick();
    AluValid = 1'b0; #1;
    check("prio_count2", Count, 2);
    check("prio_head_3", WriteAddress, 3);
    WriteReady = 1'b1;
    tick();
    check("prio_head_4", WriteAddress, 4);
    check("prio_wdata_44", WriteData, 32'h44);
    tick();
    check("prio_empty", Count, 0);

    // Full / back-pressure / wrap
    WriteReady = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      AluValid = 1'b1; AluRd = 5'(i); AluData = 32'h11 * i;
      tick();
    end
    AluRd = 5'd9; AluData = 32'h99; #1;
    check("full_count", Count, 4);
    check("full_loadready", LoadReady, 0);
    check("full_aluready", AluReady, 0);
    tick();
    AluValid = 1'b0; #1;
    check("full_no_accept", Count, 4);
    WriteReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_regwrite", RegWrite, 1);
      check("drain_waddr", WriteAddress, i);
      check("drain_wdata", WriteData, 32'h11 * i);
      tick();
      if (i == 1) check("ready_after_pop", AluReady, 1);
    end
    check("drain_empty", Count, 0);
    for (int i = 0; i < 4; i++) begin
      AluValid = 1'b1; AluRd = 5'(10 + i); AluData = 32'h100 + i;
      tick();
      check("stream_waddr", WriteAddress, 10 + i);
      check("stream_wdata", WriteData, 32'h100 + i);
      check("stream_count", Count, 1);
    end
    AluValid = 1'b0;
    tick();
    check("stream_empty", Count, 0);

    // Forwarding youngest
    WriteReady = 1'b0; ReadReg2 = 5'd7; ReadReg1 = 5'd8;
    LoadValid = 1'b1; LoadRd = 5'd7; LoadData = 32'hA; tick();
    LoadData = 32'hB; tick();
    LoadRd = 5'd8; LoadData = 32'hC; tick();
    LoadValid = 1'b0; #1;
    check("fwd_count", Count, 3);
    check("fwd_busy2", Busy2, 1);
    check("fwd_data2_youngest", FwdData2, 32'hB);
    check("fwd_data1", FwdData1, 32'hC);
    WriteReady = 1'b1;
    tick();
    check("fwd_busy2_one_left", Busy2, 1);
    check("fwd_data2_one_left", FwdData2, 32'hB);
    tick();
    check("fwd_busy2_gone", Busy2, 0);
    check("fwd_data2_gone", FwdData2, 0);
    tick();
    check("fwd_empty", Count, 0);

    // x0 discard
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    LoadValid = 1'b1; LoadRd = 5'd0; LoadData = 32'h1234; #1;
    check("x0_loadready", LoadReady, 1);
    tick();
    LoadValid = 1'b0; #1;
    check("x0_count", Count, 0);
    check("x0_regwrite", RegWrite, 0);
    check("x0_busy1", Busy1, 0);
    AluValid = 1'b1; AluRd = 5'd0; AluData = 32'h55;
    tick();
    AluValid = 1'b0; #1;
    check("x0_alu_count", Count, 0);

    // Reset mid-traffic
    WriteReady = 1'b0; ReadReg1 = 5'd2;
    for (int i = 1; i <= 3; i++) begin
      AluValid = 1'b1; AluRd = 5'(i); AluData = 32'h200 + i;
      tick();
    end
    AluValid = 1'b0; #1;
    check("midrst_count_pre", Count, 3);
    check("midrst_busy_pre", Busy1, 1);
    ResetN = 1'b0; #1;
    check("midrst_count", Count, 0);
    check("midrst_regwrite", RegWrite, 0);
    check("midrst_busy1", Busy1, 0);
    check("midrst_fwd1", FwdData1, 0);
    check("midrst_loadready", LoadReady, 0);
    tick();
    ResetN = 1'b1; WriteReady = 1'b1;
    tick();
    check("midrst_no_stale", RegWrite, 0);
    check("midrst_count_after", Count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
